// File: rtl/if_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Fetch FSM encoding and the buffered (pc, inst) entry layout live here.
package if_fetch_buffer_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_START_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] dword_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// Instruction buffer: two push lanes (lane 1 only alongside lane 0), one pop, flush.
// Head entry is read straight out of storage so decode sees it combinationally.
module fetch_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push0,
    input  logic [XLEN-1:0]         push0_pc,
    input  logic [INST_W-1:0]       push0_inst,
    input  logic                    push1,
    input  logic [XLEN-1:0]         push1_pc,
    input  logic [INST_W-1:0]       push1_inst,
    input  logic                    pop,
    output logic [XLEN-1:0]         head_pc,
    output logic [INST_W-1:0]       head_inst,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wptr, rptr, wptr_n1;
    logic [CW-1:0]  count;
    logic [1:0]     n_push;
    logic           do_pop;

    assign wptr_n1  = wptr + AW'(1);
    assign n_push   = push1 ? 2'd2 : {1'b0, push0};
    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign free_cnt = CW'(DEPTH) - count;
    assign head_pc   = mem[rptr].pc;
    assign head_inst = mem[rptr].inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            // Contents are stale after a flush; only the pointers matter.
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push0) mem[wptr]    <= '{pc: push0_pc, inst: push0_inst};
            if (push1) mem[wptr_n1] <= '{pc: push1_pc, inst: push1_inst};
            wptr  <= wptr + AW'(n_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(n_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch front end: one outstanding 64-bit imem read at a time, split into 32-bit
// instructions and buffered for decode; execute redirects flush and restart fetch.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter logic [63:0] PC_START   = PC_START_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    input  logic        id_ready
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FW-1:0] FREE_MIN = FW'(2);

    fetch_state_e     state;
    logic [XLEN-1:0]  fetch_pc, aligned;
    logic [FW-1:0]    free_cnt;
    logic             fifo_empty, resp_owed, push0, push1;
    logic [XLEN-1:0]  push0_pc;
    logic [INST_W-1:0] push0_inst;

    assign aligned   = dword_align(fetch_pc);
    assign imem_addr = aligned;
    // Gate on two free slots so a full doubleword always fits when it returns.
    assign imem_req  = (state == ST_REQ) && (free_cnt >= FREE_MIN);

    assign resp_owed = ((state == ST_WAIT || state == ST_DROP) && !imem_rvalid)
                     || ((state == ST_REQ) && imem_req && imem_gnt);

    assign push0      = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
    assign push1      = push0 && !fetch_pc[2];
    assign push0_pc   = fetch_pc[2] ? fetch_pc : aligned;
    assign push0_inst = fetch_pc[2] ? imem_rdata[63:32] : imem_rdata[31:0];

    assign id_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fetch_pc <= PC_START;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~64'h3;
            state    <= resp_owed ? ST_DROP : ST_REQ;
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ:  if (imem_req && imem_gnt) state <= ST_WAIT;
                ST_WAIT: if (imem_rvalid) begin
                    fetch_pc <= aligned + 64'd8;
                    state    <= ST_REQ;
                end
                ST_DROP: if (imem_rvalid) state <= ST_REQ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push0      (push0),
        .push0_pc   (push0_pc),
        .push0_inst (push0_inst),
        .push1      (push1),
        .push1_pc   (aligned + 64'd4),
        .push1_inst (imem_rdata[63:32]),
        .pop        (id_valid && id_ready),
        .head_pc    (id_pc),
        .head_inst  (id_inst),
        .empty      (fifo_empty),
        .free_cnt   (free_cnt)
    );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: an imem responder plus a program-order model of the
// instruction stream decode should see (sequential PCs, restarted by redirects/reset).
module tb_if_fetch_buffer;

    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

    logic        clk, rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [63:0] imem_addr, imem_rdata;
    logic        id_valid, id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;

    if_fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_pass, n_pops;
    int p_gnt, p_rdy, dmin, dmax, pend_dly;
    logic [63:0] exp_pc, exp_req, pend_addr, prev_addr;
    bit pend, pend_dead, stale, granted;
    bit prev_redir, prev_rvok, prev_hold;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
        else n_pass++;
    endtask

    // Memory image: the two spec instructions at the reset PC, a hash elsewhere.
    function automatic logic [31:0] inst_at(input logic [63:0] pc);
        if (pc == 64'h8000_0000) return 32'h0010_0093;
        if (pc == 64'h8000_0004) return 32'h0050_0093;
        return pc[31:0] ^ {pc[47:32], pc[15:0]} ^ 32'h5a5a_1234;
    endfunction

    // One clock: entered and left at negedge; inputs driven, then outputs checked.
    task automatic tick(input bit redir, input logic [63:0] rpc);
        bit rv_live;
        rv_live = 1'b0;
        granted = 1'b0;
        imem_gnt       = ($urandom_range(99) < p_gnt);
        id_ready       = ($urandom_range(99) < p_rdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = 1'b0;
        imem_rdata     = {$urandom, $urandom};
        if (pend) begin
            pend_dly--;
            if (pend_dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = {inst_at(pend_addr + 64'd4), inst_at(pend_addr)};
                rv_live     = !pend_dead;
                pend        = 1'b0;
            end
        end else if (stale) begin
            imem_rvalid = 1'b1;
            stale       = 1'b0;
        end
        #1;
        if (prev_redir) chk("flush_empty", 64'(id_valid), 64'd0);
        if (prev_rvok)  chk("rvalid_to_valid", 64'(id_valid), 64'd1);
        if (prev_hold) begin
            chk("req_hold", 64'(imem_req), 64'd1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        if (id_valid && id_ready) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_inst", 64'(id_inst), 64'(inst_at(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            n_pops++;
        end
        if (imem_req && imem_gnt) begin
            chk("req_addr", imem_addr, exp_req);
            chk("one_outstanding", 64'(pend), 64'd0);
            pend      = 1'b1;
            pend_dead = 1'b0;
            pend_addr = imem_addr;
            pend_dly  = $urandom_range(dmax, dmin);
            exp_req   = imem_addr + 64'd8;
            granted   = 1'b1;
        end
        if (redir) begin
            if (pend) pend_dead = 1'b1;
            exp_pc  = rpc & ~64'd3;
            exp_req = rpc & ~64'd7;
        end
        prev_redir = redir;
        prev_rvok  = rv_live && !redir;
        prev_hold  = imem_req && !imem_gnt && !redir;
        prev_addr  = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_until_grant(input int max_cyc);
        int n;
        n = 0;
        do begin
            tick(1'b0, 64'd0);
            n++;
        end while (!granted && n < max_cyc);
        chk("grant_timeout", 64'(granted), 64'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, PC0);
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_inst", 64'(id_inst), 64'd0);
        chk("rst_pc", id_pc, 64'd0);
    endtask

    task automatic clear_model();
        pend = 1'b0; pend_dead = 1'b0; prev_redir = 1'b0; prev_rvok = 1'b0; prev_hold = 1'b0;
        exp_pc = PC0; exp_req = PC0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
    endtask

    // Asynchronous reset in the middle of a low phase, then a stale rvalid after release.
    task automatic mid_cycle_reset();
        #3 rst = 1'b0;
        #1 check_reset_outputs();
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        stale = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_pops = 0; stale = 1'b0;
        rst = 1'b0; imem_rdata = '0; redirect_pc = '0;
        clear_model();
        p_gnt = 100; p_rdy = 100; dmin = 1; dmax = 1;
        @(negedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back grants, 1-cycle latency, decode always ready.
        repeat (8) tick(1'b0, 64'd0);
        chk("t1_pops", 64'(n_pops >= 4), 64'd1);

        // Decode stalled: buffer fills and requests stop, then drains in order.
        p_rdy = 0;
        repeat (20) tick(1'b0, 64'd0);
        chk("t2_req_stopped", 64'(imem_req), 64'd0);
        chk("t2_valid", 64'(id_valid), 64'd1);
        p_rdy = 100;
        repeat (20) tick(1'b0, 64'd0);

        // Redirect while waiting for data: response dropped, odd-word restart.
        dmin = 3; dmax = 3;
        tick_until_grant(10);
        tick(1'b1, 64'h8000_0104);
        dmin = 1; dmax = 1;
        repeat (12) tick(1'b0, 64'd0);

        // Redirect together with a pop on a partially filled buffer.
        p_rdy = 0;
        repeat (15) tick(1'b0, 64'd0);
        p_gnt = 0; p_rdy = 100;
        tick(1'b0, 64'd0);
        tick(1'b1, 64'h8000_0204);
        p_gnt = 100;
        repeat (10) tick(1'b0, 64'd0);

        // Grant withheld: request and address must hold.
        p_gnt = 0;
        tick(1'b1, 64'h8000_0300);
        repeat (6) tick(1'b0, 64'd0);
        chk("t5_req_held", 64'(imem_req), 64'd1);
        chk("t5_addr_held", imem_addr, 64'h8000_0300);
        p_gnt = 100;
        repeat (8) tick(1'b0, 64'd0);

        // Address wrap past the top of the 64-bit space.
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (10) tick(1'b0, 64'd0);

        // Reset while a response is outstanding.
        dmin = 3; dmax = 3;
        tick_until_grant(10);
        tick(1'b0, 64'd0);
        mid_cycle_reset();
        dmin = 1; dmax = 3;
        repeat (10) tick(1'b0, 64'd0);

        // Random traffic.
        p_gnt = 60; p_rdy = 70;
        n_pops = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 3)
                tick(1'b1, 64'h8000_0000 + 64'($urandom_range(1023)) * 64'd4);
            else
                tick(1'b0, 64'd0);
        end
        chk("random_progress", 64'(n_pops > 200), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Front end of the core; sits directly upstream of the decode stage.
- Holds the fetch PC and issues 64-bit aligned reads to instruction memory using a req/gnt, rvalid handshake.
- Splits each returned doubleword into 32-bit instructions and buffers them in a small FIFO.
- Presents one instruction plus its PC to decode with a valid/ready handshake; a branch/jump redirect from execute flushes the buffer.

Parameters:
- PC_START, 64'h0000_0000_8000_0000, reset fetch PC.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  64  new PC; bits [1:0] are treated as 0.
- imem_req  out  1  fetch request.
- imem_addr  out  64  doubleword address, bits [2:0] = 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; exactly one per granted request, at least 1 cycle after gnt.
- imem_rdata  in  64  doubleword; [31:0] is at addr, [63:32] is at addr+4.
- id_valid  out  1  FIFO head valid.
- id_inst  out  32  head instruction.
- id_pc  out  64  head PC.
- id_ready  in  1  decode accepts head.

Behaviour:
- Reset (rst=0, async) clears everything immediately:
  - imem_req=0, imem_addr={PC_START[63:3],3'b0}, id_valid=0, id_inst=0, id_pc=0.
  - FIFO empty, state IDLE, fetch_pc=PC_START.
- State IDLE: go to REQ on the first clock after reset release.
- State REQ:
  - imem_req=1 only when FIFO free slots >= 2; otherwise imem_req=0 and stay in REQ.
  - imem_addr={fetch_pc[63:3],3'b0}, held stable while req=1 and gnt=0.
  - req&gnt: go to WAIT.
- State WAIT (imem_req=0):
  - On rvalid, if fetch_pc[2]==0: push {rdata[31:0], pc=aligned}, then {rdata[63:32], pc=aligned+4}, both in the same cycle.
  - If fetch_pc[2]==1: push only {rdata[63:32], fetch_pc}.
  - Then fetch_pc <= aligned+8 (wraps modulo 2^64) and go to REQ.
- State DROP: the redirect target is already loaded; discard the next rvalid (no push), then go to REQ.
- Redirect (highest priority, any state):
  - fetch_pc <= {redirect_pc[63:2],2'b0}; FIFO flushed next cycle.
  - Next state is DROP if a response is owed: currently in WAIT without rvalid this cycle, in REQ with req&gnt this cycle, or already in DROP without rvalid.
  - Otherwise next state is REQ.
  - An rvalid arriving in the same cycle as the redirect is discarded.
- Redirect in the same cycle as an id pop: the flush wins and the popped entry is lost; decode is flushed by the same redirect.
- Output side:
  - id_valid = FIFO not empty; id_inst and id_pc show the head combinationally from FIFO storage.
  - Pop on id_valid&id_ready.
  - Push and pop in the same cycle are allowed.
- No-overflow guarantee: one outstanding request max, issued only with >= 2 free slots; pops only add space.
- Latency: redirect to first imem_req is 1 cycle (REQ) or 1 cycle after the owed rvalid (DROP). rvalid to id_valid is 1 cycle.
- rvalid outside WAIT/DROP is ignored.

Decomposition:
- Shared package:
  - PC_START default.
  - INST_W=32, XLEN=64.
  - Fetch FSM state encoding: IDLE, REQ, WAIT, DROP (2-bit).
- One sub-module: fetch_fifo.
  - Synchronous FIFO, DEPTH entries of {pc[63:0], inst[31:0]}.
  - Dual push port (push0, push1; push1 only with push0), single pop, flush.
  - Outputs: free-count, empty.

Test Plan:
1. Release reset with gnt=1 and rvalid 1 cycle later, rdata=64'h00500093_00100093, id_ready=1 -> imem_addr=0x80000000; id_valid with pc 0x80000000 / inst 0x00100093, then 0x80000004 / 0x00500093; next imem_addr=0x80000008.
2. id_ready=0 with continuous grants -> FIFO reaches 4 entries; imem_req drops once free<2. Setting id_ready=1 drains in order (pc +4 each) and requests resume; no entry lost or duplicated.
3. Redirect to 0x80000104 while in WAIT -> the following rvalid is dropped; next imem_addr=0x80000100; only rdata[63:32] is pushed, with pc 0x80000104.
4. Redirect and pop in the same cycle with 3 entries buffered -> next cycle id_valid=0; first new instruction carries the redirect PC.
5. imem_gnt held 0 for 5 cycles in REQ -> imem_req=1 and imem_addr unchanged throughout; gnt on cycle 6 moves to WAIT.
6. Assert rst mid-WAIT, then a stale rvalid after release -> outputs clear immediately; stale rvalid ignored; fetch restarts at 0x80000000.
